// File: rtl/id_stage_pipe.sv
// RISC-V integer-ALU decode stage: registered bundle with valid/ready on both sides.
// Optional macro ID_FORWARD_EN: forward EX/MEM writes instead of stalling on RAW hazards.

module id_src_sel #(
  parameter int XLEN = 64
) (
  input  logic            en,
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_wen,
  input  logic [4:0]      ex_waddr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            mem_wen,
  input  logic [4:0]      mem_waddr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [4:0]      addr,
  output logic [XLEN-1:0] val,
  output logic            stall
);
  logic ex_hit, mem_hit;

  assign addr    = en ? rs : 5'd0;
  assign ex_hit  = ex_wen && (ex_waddr == rs);
  assign mem_hit = mem_wen && (mem_waddr == rs);

  // Without forwarding a hit always stalls, so the forwarded value is never
  // captured and this mux reduces to the regfile value in that build.
  always_comb begin
    if (rs == 5'd0)   val = '0;
    else if (ex_hit)  val = ex_wdata;
    else if (mem_hit) val = mem_wdata;
    else              val = rf_data;
  end

`ifdef ID_FORWARD_EN
  assign stall = 1'b0;
`else
  assign stall = en && (rs != 5'd0) && (ex_hit || mem_hit);
`endif
endmodule

module id_stage_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            reg1_read_enable,
  output logic            reg2_read_enable,
  output logic [4:0]      reg1_addr,
  output logic [4:0]      reg2_addr,
  input  logic [XLEN-1:0] reg1_data,
  input  logic [XLEN-1:0] reg2_data,
  input  logic            ex_wen,
  input  logic [4:0]      ex_waddr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            mem_wen,
  input  logic [4:0]      mem_waddr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [7:0]      aluop_o,
  output logic [3:0]      alusel_o,
  output logic [XLEN-1:0] oprand1,
  output logic [XLEN-1:0] oprand2,
  output logic [4:0]      reg_write_addr_o,
  output logic            reg_write_enable_o,
  output logic            illegal_o
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic       HAS_WORD   = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [7:0]      aluop;
    logic [3:0]      alusel;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } bundle_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_op, is_imm, is_lui, is_auipc, is_word, legal, alt;
  logic [1:0]  src_en, src_stall;
  logic [1:0][4:0]      src_rs, src_addr;
  logic [1:0][XLEN-1:0] src_rf, src_val;
  logic signed [11:0]   imm_i_s;
  logic signed [31:0]   imm_u_s;
  logic [XLEN-1:0]      imm_i, imm_u;
  logic        hazard_stall;
  bundle_t     dec, q;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];

  always_comb begin
    is_op = 1'b0; is_imm = 1'b0; is_lui = 1'b0; is_auipc = 1'b0; is_word = 1'b0;
    case (opc)
      OPC_OP:    is_op = 1'b1;
      OPC_IMM:   is_imm = 1'b1;
      OPC_LUI:   is_lui = 1'b1;
      OPC_AUIPC: is_auipc = 1'b1;
      OPC_OP32:  begin is_op  = HAS_WORD; is_word = HAS_WORD; end
      OPC_IMM32: begin is_imm = HAS_WORD; is_word = HAS_WORD; end
      default:   ;
    endcase
  end

  assign legal   = is_op | is_imm | is_lui | is_auipc;
  // Only the shift-immediates carry an arithmetic/logical select in bit 30.
  assign alt     = is_op ? in_inst[30] : (is_imm && f3[1:0] == 2'b01) ? in_inst[30] : 1'b0;
  assign imm_i_s = in_inst[31:20];
  assign imm_u_s = {in_inst[31:12], 12'b0};
  assign imm_i   = XLEN'(imm_i_s);
  assign imm_u   = XLEN'(imm_u_s);

  assign src_en = {is_op, is_op | is_imm};
  assign src_rs = {in_inst[24:20], in_inst[19:15]};
  assign src_rf = {reg2_data, reg1_data};

  for (genvar i = 0; i < 2; i++) begin : g_src
    id_src_sel #(.XLEN(XLEN)) u_src (
      .en(src_en[i]), .rs(src_rs[i]), .rf_data(src_rf[i]),
      .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .addr(src_addr[i]), .val(src_val[i]), .stall(src_stall[i])
    );
  end

  assign reg1_read_enable = src_en[0];
  assign reg2_read_enable = src_en[1];
  assign reg1_addr        = src_addr[0];
  assign reg2_addr        = src_addr[1];
  assign hazard_stall     = |src_stall;

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.ill = !legal;
    if (legal) begin
      dec.alusel = 4'd1;
      dec.we     = 1'b1;
      dec.rd     = in_inst[11:7];
      dec.aluop  = (is_op || is_imm) ? {3'b0, is_word, alt, f3} : 8'h00;
      dec.op1    = is_auipc ? in_pc : is_lui ? '0 : src_val[0];
      dec.op2    = is_op ? src_val[1] : is_imm ? imm_i : imm_u;
    end
  end

  assign in_ready = !rst && !hazard_stall && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc             = q.pc;
  assign aluop_o            = q.aluop;
  assign alusel_o           = q.alusel;
  assign oprand1            = q.op1;
  assign oprand2            = q.op2;
  assign reg_write_addr_o   = q.rd;
  assign reg_write_enable_o = q.we;
  assign illegal_o          = q.ill;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized traffic
// against a behavioural decode/handshake model. Honours ID_FORWARD_EN.

module tb_id_stage_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, reg1_data, reg2_data, ex_wdata, mem_wdata, out_pc, oprand1, oprand2;
  logic [31:0] in_inst;
  logic        reg1_read_enable, reg2_read_enable, ex_wen, mem_wen;
  logic [4:0]  reg1_addr, reg2_addr, ex_waddr, mem_waddr, reg_write_addr_o;
  logic [7:0]  aluop_o;
  logic [3:0]  alusel_o;
  logic        reg_write_enable_o, illegal_o;
  logic [63:0] regs [32];

  assign reg1_data = regs[reg1_addr];
  assign reg2_data = regs[reg2_addr];

  id_stage_pipe #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .reg1_read_enable(reg1_read_enable), .reg2_read_enable(reg2_read_enable),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg1_data(reg1_data), .reg2_data(reg2_data),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .aluop_o(aluop_o),
    .alusel_o(alusel_o), .oprand1(oprand1), .oprand2(oprand2),
    .reg_write_addr_o(reg_write_addr_o), .reg_write_enable_o(reg_write_enable_o),
    .illegal_o(illegal_o)
  );

  // 32-bit instance, only used to check that W-forms are rejected.
  logic        in_valid32, in_ready32, out_ready32, out_valid32, r1en32, r2en32;
  logic [31:0] inst32, pc_out32, op1_32, op2_32;
  logic [31:0] zero32 = '0;
  logic [4:0]  a1_32, a2_32, rd32;
  logic [7:0]  aluop32;
  logic [3:0]  alusel32;
  logic        we32, ill32;
  logic        zero1 = 1'b0;
  logic [4:0]  zero5 = '0;

  id_stage_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_pc(zero32), .in_inst(inst32),
    .reg1_read_enable(r1en32), .reg2_read_enable(r2en32),
    .reg1_addr(a1_32), .reg2_addr(a2_32), .reg1_data(zero32), .reg2_data(zero32),
    .ex_wen(zero1), .ex_waddr(zero5), .ex_wdata(zero32),
    .mem_wen(zero1), .mem_waddr(zero5), .mem_wdata(zero32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_pc(pc_out32), .aluop_o(aluop32),
    .alusel_o(alusel32), .oprand1(op1_32), .oprand2(op2_32),
    .reg_write_addr_o(rd32), .reg_write_enable_o(we32), .illegal_o(ill32)
  );

  wire [147:0] obs = {out_valid, aluop_o, alusel_o, oprand1, oprand2,
                      reg_write_addr_o, reg_write_enable_o, illegal_o};
  localparam logic [147:0] ADD_OBS = {1'b1, 8'h00, 4'd1, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0};

  int checks = 0;
  int errs   = 0;

  typedef struct {
    logic [7:0]  aluop;
    logic [3:0]  sel;
    logic [63:0] o1, o2, pc;
    logic [4:0]  rd, a1, a2;
    logic        we, ill, en1, en2, stall;
  } exp_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic hit(logic [4:0] rs);
    return (ex_wen && ex_waddr == rs) || (mem_wen && mem_waddr == rs);
  endfunction

  function automatic logic [63:0] srcval(logic [4:0] rs);
    if (rs == 0) return 64'd0;
`ifdef ID_FORWARD_EN
    if (ex_wen && ex_waddr == rs) return ex_wdata;
    if (mem_wen && mem_waddr == rs) return mem_wdata;
`endif
    return regs[rs];
  endfunction

  // Reference decode straight from the ISA rules.
  function automatic exp_t ref_decode(logic [31:0] inst, logic [63:0] pc);
    exp_t e;
    logic [6:0] opc = inst[6:0];
    logic [2:0] f3 = inst[14:12];
    logic [4:0] rs1 = inst[19:15];
    logic [4:0] rs2 = inst[24:20];
    longint unsigned immi = longint'($signed(inst) >>> 20);
    longint unsigned immu = longint'($signed(inst & 32'hFFFFF000));
    e = '{aluop: 8'h0, sel: 4'd1, o1: 64'd0, o2: 64'd0, pc: pc, rd: inst[11:7], a1: 5'd0,
          a2: 5'd0, we: 1'b1, ill: 1'b0, en1: 1'b0, en2: 1'b0, stall: 1'b0};
    case (opc)
      7'h33, 7'h3B: begin
        e.en1 = 1; e.en2 = 1; e.o1 = srcval(rs1); e.o2 = srcval(rs2);
        e.aluop = {3'b0, opc == 7'h3B, inst[30], f3};
      end
      7'h13, 7'h1B: begin
        e.en1 = 1; e.o1 = srcval(rs1); e.o2 = immi;
        e.aluop = {3'b0, opc == 7'h1B, (f3 == 3'd1 || f3 == 3'd5) ? inst[30] : 1'b0, f3};
      end
      7'h37: e.o2 = immu;
      7'h17: begin e.o1 = pc; e.o2 = immu; end
      default: begin e.ill = 1; e.we = 0; e.sel = 0; end
    endcase
    e.a1 = e.en1 ? rs1 : 5'd0;
    e.a2 = e.en2 ? rs2 : 5'd0;
`ifndef ID_FORWARD_EN
    e.stall = (e.en1 && rs1 != 0 && hit(rs1)) || (e.en2 && rs2 != 0 && hit(rs2));
`endif
    return e;
  endfunction

  task automatic test_reset();
    rst = 1; tick(); tick();
    checks++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got=%b exp=0", in_ready); errs++; end
    checks++; if (obs !== '0 || out_pc !== '0) begin $display("FAIL reset_outputs got=%h pc=%h exp=0", obs, out_pc); errs++; end
    in_valid = 1; in_inst = 32'h002081B3; out_ready = 1; tick();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_accept got=%b exp=0", out_valid); errs++; end
    in_valid = 0; rst = 0; tick();
  endtask

  task automatic test_decode();
    logic [31:0]  ti [6];
    logic [63:0]  tp [6];
    logic [147:0] te [6];
    logic [11:0]  ta [6];
    regs[1] = 64'd5; regs[2] = 64'd7; out_ready = 1;
    ti[0] = 32'h002081B3; tp[0] = 64'h1000;     ta[0] = {2'b11, 5'd1, 5'd2};
    te[0] = ADD_OBS;
    ti[1] = 32'h402081B3; tp[1] = 64'h1004;     ta[1] = {2'b11, 5'd1, 5'd2};
    te[1] = {1'b1, 8'h08, 4'd1, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0};
    ti[2] = 32'hFFF00093; tp[2] = 64'h1008;     ta[2] = {2'b10, 5'd0, 5'd0};
    te[2] = {1'b1, 8'h00, 4'd1, 64'd0, {64{1'b1}}, 5'd1, 1'b1, 1'b0};
    ti[3] = 32'h123452B7; tp[3] = 64'h100C;     ta[3] = '0;
    te[3] = {1'b1, 8'h00, 4'd1, 64'd0, 64'h12345000, 5'd5, 1'b1, 1'b0};
    ti[4] = 32'h00001297; tp[4] = 64'h80000000; ta[4] = '0;
    te[4] = {1'b1, 8'h00, 4'd1, 64'h80000000, 64'h1000, 5'd5, 1'b1, 1'b0};
    ti[5] = 32'h002081BB; tp[5] = 64'h1010;     ta[5] = {2'b11, 5'd1, 5'd2};
    te[5] = {1'b1, 8'h10, 4'd1, 64'd5, 64'd7, 5'd3, 1'b1, 1'b0};
    // Back-to-back: in_valid stays high across all entries.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_inst = ti[i]; in_pc = tp[i]; #1;
      checks++; if (in_ready !== 1'b1) begin $display("FAIL dec%0d_in_ready got=%b exp=1", i, in_ready); errs++; end
      checks++; if ({reg1_read_enable, reg2_read_enable, reg1_addr, reg2_addr} !== ta[i]) begin
        $display("FAIL dec%0d_rfport got=%h exp=%h", i, {reg1_read_enable, reg2_read_enable, reg1_addr, reg2_addr}, ta[i]); errs++; end
      tick();
      checks++; if (obs !== te[i] || out_pc !== tp[i]) begin
        $display("FAIL dec%0d_bundle got=%h pc=%h exp=%h pc=%h", i, obs, out_pc, te[i], tp[i]); errs++; end
    end
    in_inst = 32'h0000007F; #1;
    checks++; if ({reg1_read_enable, reg2_read_enable} !== 2'b00) begin $display("FAIL ill_rden got=%b exp=00", {reg1_read_enable, reg2_read_enable}); errs++; end
    tick();
    checks++; if ({out_valid, alusel_o, oprand1, oprand2, reg_write_enable_o, illegal_o} !== {1'b1, 4'd0, 128'd0, 1'b0, 1'b1}) begin
      $display("FAIL illegal got v=%b sel=%h o1=%h o2=%h we=%b ill=%b exp v=1 sel=0 o=0 we=0 ill=1", out_valid, alusel_o, oprand1, oprand2, reg_write_enable_o, illegal_o); errs++; end
    in_valid = 0; tick();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL drain got=%b exp=0", out_valid); errs++; end
  endtask

  task automatic test_backpressure();
    regs[1] = 64'd5; regs[2] = 64'd7;
    in_valid = 1; in_inst = 32'h002081B3; out_ready = 0; tick();
    in_inst = 32'h402081B3; regs[1] = 64'd9;
    for (int c = 0; c < 3; c++) begin
      checks++; if (in_ready !== 1'b0 || obs !== ADD_OBS) begin
        $display("FAIL hold%0d got rdy=%b obs=%h exp rdy=0 obs=%h", c, in_ready, obs, ADD_OBS); errs++; end
      tick();
    end
    in_valid = 0; flush = 1; tick(); flush = 0;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_hold got=%b exp=0", out_valid); errs++; end
    // Flush drops a same-cycle input even though in_ready is high.
    in_valid = 1; flush = 1; #1;
    checks++; if (in_ready !== 1'b1) begin $display("FAIL flush_in_ready got=%b exp=1", in_ready); errs++; end
    tick(); flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_drop got=%b exp=0", out_valid); errs++; end
    regs[1] = 64'd5; in_valid = 1; in_inst = 32'h002081B3; tick(); in_valid = 0;
    checks++; if (obs !== ADD_OBS) begin $display("FAIL pre_rst got=%h exp=%h", obs, ADD_OBS); errs++; end
    rst = 1; tick(); rst = 0;
    checks++; if (obs !== '0 || out_pc !== '0) begin $display("FAIL mid_rst got=%h pc=%h exp=0", obs, out_pc); errs++; end
    out_ready = 1; tick();
  endtask

  task automatic test_hazard();
    regs[1] = 64'd5; regs[2] = 64'd7; out_ready = 1;
    ex_wen = 1; ex_waddr = 5'd1; ex_wdata = 64'h99;
    mem_wen = 1; mem_waddr = 5'd1; mem_wdata = 64'h55;
    in_valid = 1; in_inst = 32'h002081B3; #1;
`ifdef ID_FORWARD_EN
    checks++; if (in_ready !== 1'b1) begin $display("FAIL fwd_in_ready got=%b exp=1", in_ready); errs++; end
    tick();
    checks++; if (out_valid !== 1'b1 || oprand1 !== 64'h99) begin $display("FAIL fwd_ex got v=%b o1=%h exp v=1 o1=99", out_valid, oprand1); errs++; end
    ex_wen = 0; tick();
    checks++; if (oprand1 !== 64'h55) begin $display("FAIL fwd_mem got=%h exp=55", oprand1); errs++; end
`else
    checks++; if (in_ready !== 1'b0) begin $display("FAIL stall_both got=%b exp=0", in_ready); errs++; end
    tick();
    checks++; if (out_valid !== 1'b0) begin $display("FAIL stall_no_issue got=%b exp=0", out_valid); errs++; end
    ex_wen = 0; #1;
    checks++; if (in_ready !== 1'b0) begin $display("FAIL stall_mem got=%b exp=0", in_ready); errs++; end
    tick(); mem_wen = 0; #1;
    checks++; if (in_ready !== 1'b1) begin $display("FAIL stall_clear got=%b exp=1", in_ready); errs++; end
    tick();
    checks++; if (out_valid !== 1'b1 || oprand1 !== 64'd5) begin $display("FAIL stall_value got v=%b o1=%h exp v=1 o1=5", out_valid, oprand1); errs++; end
`endif
    ex_wen = 0; mem_wen = 0; in_valid = 0; tick();
  endtask

  task automatic test_xlen32();
    out_ready32 = 1; in_valid32 = 1; inst32 = 32'h002081BB; tick();
    checks++; if ({out_valid32, ill32, we32} !== 3'b110) begin $display("FAIL x32_addw got v/ill/we=%b exp=110", {out_valid32, ill32, we32}); errs++; end
    inst32 = 32'h002081B3; tick();
    checks++; if ({out_valid32, ill32, we32} !== 3'b101) begin $display("FAIL x32_add got v/ill/we=%b exp=101", {out_valid32, ill32, we32}); errs++; end
    in_valid32 = 0; tick();
  endtask

  task automatic test_random();
    exp_t cur, mb;
    logic mv, exp_rdy;
    logic [31:0] r;
    rst = 1; tick(); rst = 0; mv = 0;
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 32; j++) regs[j] = {$urandom, $urandom};
      r = $urandom;
      if ($urandom % 2 == 0) r &= 32'hFE31FFFF;   // narrow rs fields to provoke hits
      case ($urandom % 7)
        0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h37;  3: r[6:0] = 7'h17;
        4: r[6:0] = 7'h3B;  5: r[6:0] = 7'h1B;  default: r[6:0] = 7'h63;
      endcase
      in_inst = r; in_pc = {$urandom, $urandom};
      in_valid = ($urandom % 4) != 0; out_ready = ($urandom % 4) != 0; flush = ($urandom % 16) == 0;
      ex_wen = ($urandom % 3) == 0;  ex_waddr = 5'($urandom_range(0, 3));  ex_wdata = {$urandom, $urandom};
      mem_wen = ($urandom % 3) == 0; mem_waddr = 5'($urandom_range(0, 3)); mem_wdata = {$urandom, $urandom};
      #1;
      cur = ref_decode(in_inst, in_pc);
      exp_rdy = !cur.stall && (!mv || out_ready);
      checks++; if (in_ready !== exp_rdy) begin $display("FAIL rnd%0d_in_ready got=%b exp=%b", n, in_ready, exp_rdy); errs++; end
      checks++; if ({reg1_read_enable, reg2_read_enable, reg1_addr, reg2_addr} !== {cur.en1, cur.en2, cur.a1, cur.a2}) begin
        $display("FAIL rnd%0d_rfport got=%h exp=%h", n, {reg1_read_enable, reg2_read_enable, reg1_addr, reg2_addr}, {cur.en1, cur.en2, cur.a1, cur.a2}); errs++; end
      if (flush) mv = 0;
      else if (in_valid && exp_rdy) begin mv = 1; mb = cur; end
      else if (out_ready) mv = 0;
      tick();
      checks++; if (out_valid !== mv) begin $display("FAIL rnd%0d_valid got=%b exp=%b", n, out_valid, mv); errs++; end
      if (mv) begin
        checks++; if ({alusel_o, oprand1, oprand2, reg_write_enable_o, illegal_o, out_pc} !== {mb.sel, mb.o1, mb.o2, mb.we, mb.ill, mb.pc}) begin
          $display("FAIL rnd%0d_bundle got sel=%h o1=%h o2=%h we=%b ill=%b pc=%h exp sel=%h o1=%h o2=%h we=%b ill=%b pc=%h", n,
                   alusel_o, oprand1, oprand2, reg_write_enable_o, illegal_o, out_pc, mb.sel, mb.o1, mb.o2, mb.we, mb.ill, mb.pc); errs++; end
        if (!mb.ill) begin
          checks++; if ({aluop_o, reg_write_addr_o} !== {mb.aluop, mb.rd}) begin
            $display("FAIL rnd%0d_aluop_rd got=%h/%0d exp=%h/%0d", n, aluop_o, reg_write_addr_o, mb.aluop, mb.rd); errs++; end
        end
      end
    end
    in_valid = 0; flush = 0; ex_wen = 0; mem_wen = 0; out_ready = 1; tick();
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_inst = '0;
    ex_wen = 0; ex_waddr = '0; ex_wdata = '0; mem_wen = 0; mem_waddr = '0; mem_wdata = '0;
    in_valid32 = 0; out_ready32 = 0; inst32 = '0;
    for (int j = 0; j < 32; j++) regs[j] = 64'hDEAD_0000 + 64'(j);
    test_reset();
    test_decode();
    test_backpressure();
    test_hazard();
    test_xlen32();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered RISC-V instruction-decode stage with a valid/ready handshake on both sides.
- Decodes the integer ALU subset (OP, OP-IMM, LUI, AUIPC, and the W-forms OP-32 / OP-IMM-32 when XLEN=64).
- Generates immediates, reads two register-file ports, resolves RAW hazards against EX/MEM writebacks, and presents one decoded bundle per cycle to EX.
- Sits between the fetch buffer and the ALU/EX stage.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. When 32, OP-32 and OP-IMM-32 decode as illegal.

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  kill the output bundle and drop the input this cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts an instruction this cycle
in_pc  in  XLEN  PC of the presented instruction
in_inst  in  32  instruction word
reg1_read_enable  out  1  regfile port 1 read enable (combinational)
reg2_read_enable  out  1  regfile port 2 read enable (combinational)
reg1_addr  out  5  regfile port 1 address (combinational)
reg2_addr  out  5  regfile port 2 address (combinational)
reg1_data  in  XLEN  asynchronous regfile read data, port 1
reg2_data  in  XLEN  asynchronous regfile read data, port 2
ex_wen, ex_waddr, ex_wdata  in  1/5/XLEN  EX-stage pending write
mem_wen, mem_waddr, mem_wdata  in  1/5/XLEN  MEM-stage pending write
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts the bundle
out_pc  out  XLEN  registered PC
aluop_o  out  8  {3'b0, word, alt, funct3}
alusel_o  out  4  0 = none, 1 = ALU
oprand1  out  XLEN  ALU operand 1
oprand2  out  XLEN  ALU operand 2
reg_write_addr_o  out  5  destination register (rd)
reg_write_enable_o  out  1  writeback enable
illegal_o  out  1  unsupported opcode

Behaviour:
- Reset: rst, synchronous, active-high. All registered outputs go to 0: out_valid, out_pc, aluop_o, alusel_o, oprand1, oprand2, reg_write_addr_o, reg_write_enable_o, illegal_o. in_ready = 0 while rst is high.
- Reset mid-operation discards any held bundle.
- Decode is combinational from in_inst. Register-file address and enable outputs are combinational.
- Read enables by opcode:
  - OP, OP-32: rs1 and rs2.
  - OP-IMM, OP-IMM-32: rs1 only.
  - LUI, AUIPC: none.
  - Disabled ports drive address 0.
- Opcodes decoded: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, OP-32 0111011, OP-IMM-32 0011011. Anything else sets illegal_o = 1, reg_write_enable_o = 0, alusel_o = 0, operands = 0.
- Operands:
  - OP: opr1 = rs1 value, opr2 = rs2 value.
  - OP-IMM: opr2 = sign-extended inst[31:20].
  - LUI: opr1 = 0, opr2 = sign-extended {inst[31:12], 12'b0}; aluop = ADD (0x00).
  - AUIPC: opr1 = in_pc, opr2 = same immediate as LUI; aluop = ADD.
- aluop fields:
  - word = 1 for the OP-32 and OP-IMM-32 forms.
  - alt = inst[30] for OP and OP-32.
  - alt = inst[30] for OP-IMM shifts (funct3 001/101); alt = 0 for all other OP-IMM.
- reg_write_enable_o = 1 for every legal decode. rd = 0 is still passed through; the regfile ignores writes to x0.
- Handshake:
  - in_ready = !hazard_stall && (!out_valid || out_ready).
  - Transfer occurs when in_valid && in_ready; the bundle is registered, giving one cycle of latency to out_valid.
  - While out_valid && !out_ready, all outputs hold stable.
  - If out_ready is high and no transfer occurs, out_valid clears next cycle.
- Flush has priority over accept and hold: out_valid = 0 next cycle, and a same-cycle input is dropped. in_ready may be high during flush (fetch sees the input consumed).
- Register value per source operand, priority order:
  1. x0 always reads 0.
  2. EX match (ex_wen && ex_waddr == rs).
  3. MEM match.
  4. Regfile data.
- Stable values are sampled at the accept edge.

Optional Feature:
ID_FORWARD_EN
- Defined: EX/MEM matches forward ex_wdata / mem_wdata as above; hazard_stall is always 0.
- Undefined: no forwarding. hazard_stall = 1 while any enabled, nonzero source matches a pending EX or MEM write, so in_ready stays 0 until the match clears. The regfile value is then used.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), reg1_data = 5, reg2_data = 7, out_ready = 1 -> next cycle out_valid = 1, oprand1 = 5, oprand2 = 7, aluop_o = 0x00, alusel_o = 1, reg_write_addr_o = 3, reg_write_enable_o = 1.
- SUB x3,x1,x2 (0x402081B3) -> aluop_o = 0x08. ADDI x1,x0,-1 (0xFFF00093) -> oprand1 = 0, oprand2 = 0xFFFFFFFFFFFFFFFF.
- LUI x5,0x12345 (0x123452B7) -> oprand1 = 0, oprand2 = 0x0000000012345000. AUIPC x5,0x1 at pc 0x80000000 -> oprand1 = 0x80000000, oprand2 = 0x1000.
- Backpressure: out_ready = 0 for 3 cycles after a valid bundle -> outputs hold unchanged, in_ready = 0. Flush during the hold -> out_valid = 0 next cycle.
- ADD x3,x1,x2 with ex_wen = 1, ex_waddr = 1, ex_wdata = 0x99, and mem_wen = 1, mem_waddr = 1, mem_wdata = 0x55:
  - ID_FORWARD_EN defined -> oprand1 = 0x99.
  - Undefined -> in_ready = 0 until both wens drop, then oprand1 = reg1_data.
- Illegal word 0x0000007F -> illegal_o = 1, reg_write_enable_o = 0. With XLEN = 32, ADDW (0x002081BB) -> illegal_o = 1. rst asserted with out_valid = 1 -> all outputs 0 next cycle.
